// File: rtl/aludec_muldiv.sv
// EX-stage ALU decoder with an iterative MIPS multiply/divide engine.
// Decodes aluop/func into alucontrol, selects HI/LO for mfhi/mflo, and
// runs mult/multu/div/divu over WIDTH cycles with a stall handshake.
module aludec_muldiv #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [1:0]        aluop,
    input  logic [5:0]        func,
    input  logic [WIDTH-1:0]  srca,
    input  logic [WIDTH-1:0]  srcb,
    output logic [CTRL_W-1:0] alucontrol,
    output logic [1:0]        hilosel,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              busy,
    output logic              stall,
    output logic              illegal
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier bits / dividend bits then quotient
    logic             is_div;
    logic             neg_q;      // product or quotient must be negated
    logic             neg_r;      // remainder must be negated
    logic             div0;

    logic [3:0]       code;
    logic             is_md_start;
    logic             is_hilo_fn;
    logic             rtype;
    logic             start;
    logic             mt_hi;
    logic             mt_lo;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [2*WIDTH-1:0] product;

    assign busy  = (state != IDLE);
    assign rtype = aluop[1];

    // func/aluop decode into ALU control, result select and instruction class
    always_comb begin
        code        = 4'b0100;
        illegal     = 1'b0;
        hilosel     = 2'b00;
        is_md_start = 1'b0;
        is_hilo_fn  = 1'b0;
        if (!rtype) begin
            code = aluop[0] ? 4'b1100 : 4'b0100;
        end else begin
            case (func)
                F_ADD:   code = 4'b0100;
                F_SUB:   code = 4'b1100;
                F_AND:   code = 4'b0000;
                F_OR:    code = 4'b0001;
                F_SLT:   code = 4'b1111;
                F_SLTU:  code = 4'b1110;
                F_SLL:   code = 4'b0010;
                F_SRL:   code = 4'b0011;
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    is_md_start = 1'b1;
                    is_hilo_fn  = 1'b1;
                end
                F_MFHI: begin
                    hilosel    = 2'b01;
                    is_hilo_fn = 1'b1;
                end
                F_MFLO: begin
                    hilosel    = 2'b10;
                    is_hilo_fn = 1'b1;
                end
                F_MTHI, F_MTLO: is_hilo_fn = 1'b1;
                default: illegal = valid;
            endcase
        end
        alucontrol = CTRL_W'(code);
    end

    assign stall = valid & rtype & busy & is_hilo_fn;
    assign start = valid & rtype & is_md_start & ~busy;
    assign mt_hi = valid & rtype & (func == F_MTHI) & ~busy;
    assign mt_lo = valid & rtype & (func == F_MTLO) & ~busy;

    // operand magnitudes and per-iteration arithmetic for both engines
    always_comb begin
        sgn       = ~func[0];
        a_neg     = sgn & srca[WIDTH-1];
        b_neg     = sgn & srcb[WIDTH-1];
        mag_a     = a_neg ? -srca : srca;
        mag_b     = b_neg ? -srcb : srcb;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_sub   = div_shift[WIDTH-1:0] - mcand;
        product   = {acc_hi, acc_lo};
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // next-state: IDLE -> RUN on start, RUN for WIDTH edges, one FIX edge
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == LAST) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // datapath: operand capture, shift-add / restoring iterations, sign fix, HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // multiply is commutative, so both ops load srca into the
                        // shifting register and srcb into the fixed operand
                        mcand  <= mag_b;
                        acc_lo <= mag_a;
                        acc_hi <= '0;
                        count  <= '0;
                        is_div <= func[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div0   <= (srcb == '0);
                    end
                    if (mt_hi) hi <= srca;
                    if (mt_lo) lo <= srca;
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (!is_div) begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end else if (div_ge) begin
                        acc_hi <= div_sub;
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= neg_q ? -product : product;
                    end else begin
                        // divide-by-zero leaves the dividend magnitude as remainder;
                        // re-applying its sign reproduces srca exactly
                        lo <= div0 ? '1 : (neg_q ? -acc_lo : acc_lo);
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aludec_muldiv.sv
// Directed bench for aludec_muldiv: decode sweep, mult/div results and
// latency, stall handshake, back-to-back ops, mid-run reset, mthi/mtlo.
module tb_aludec_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [3:0]  alucontrol;
    logic [1:0]  hilosel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    logic [5:0] sweep_f [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00, 6'h02,
                                 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13};
    logic [3:0] sweep_c [16] = '{4'h4, 4'hC, 4'h0, 4'h1, 4'hF, 4'hE, 4'h2, 4'h3,
                                 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};

    aludec_muldiv #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .aluop(aluop), .func(func),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .hilosel(hilosel),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        valid = v; aluop = op; func = f; srca = a; srcb = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, {32'h0, hi}, {32'h0, e[63:32]});
            check({tag, "_lo"}, {32'h0, lo}, {32'h0, e[31:0]});
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int n;
        drive(1'b1, 2'b10, f, a, b);
        exp_q.push_back(exp);
        tick();
        check({tag, "_busy"}, {63'h0, busy}, 64'h1);
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        wait_idle(n);
        check({tag, "_lat"}, 64'(n), 64'd33);
        pop_check(tag);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        check("rst_stall", {63'h0, stall}, 64'h0);

        // decode sweep
        drive(1'b0, 2'b00, 6'h3F, '0, '0); settle();
        check("dec_aluop00", {60'h0, alucontrol}, 64'h4);
        drive(1'b0, 2'b01, 6'h3F, '0, '0); settle();
        check("dec_aluop01", {60'h0, alucontrol}, 64'hC);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 2'b10, sweep_f[i], '0, '0); settle();
            check($sformatf("dec_func_%02h", sweep_f[i]), {60'h0, alucontrol}, {60'h0, sweep_c[i]});
        end
        tick();
        drive(1'b1, 2'b10, 6'h3F, '0, '0); settle();
        check("dec_ill_code", {60'h0, alucontrol}, 64'h4);
        check("dec_ill", {63'h0, illegal}, 64'h1);
        drive(1'b1, 2'b00, 6'h3F, '0, '0); settle();
        check("dec_ill_aluop00", {63'h0, illegal}, 64'h0);
        drive(1'b0, 2'b10, 6'h3F, '0, '0); settle();
        check("dec_ill_novalid", {63'h0, illegal}, 64'h0);
        drive(1'b1, 2'b10, 6'h20, '0, '0); settle();
        check("dec_add_legal", {63'h0, illegal}, 64'h0);
        drive(1'b0, 2'b10, 6'h10, '0, '0); settle();
        check("dec_mfhi_sel", {62'h0, hilosel}, 64'h1);
        drive(1'b0, 2'b10, 6'h12, '0, '0); settle();
        check("dec_mflo_sel", {62'h0, hilosel}, 64'h2);
        drive(1'b0, 2'b00, 6'h10, '0, '0); settle();
        check("dec_mfhi_aluop00", {62'h0, hilosel}, 64'h0);
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        tick();

        // multiply / divide results and latency
        run_op("multu", 6'h19, 32'hFFFFFFFF, 32'h2, {32'h00000001, 32'hFFFFFFFE});
        run_op("mult", 6'h18, 32'hFFFFFFFD, 32'h5, {32'hFFFFFFFF, 32'hFFFFFFF1});
        run_op("div", 6'h1A, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("divu0", 6'h1B, 32'h7, 32'h0, {32'h00000007, 32'hFFFFFFFF});
        run_op("divovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});

        // stall handshake: add passes, mflo held until busy drops
        drive(1'b1, 2'b10, 6'h18, 32'd6, 32'd7);
        exp_q.push_back({32'h0, 32'd42});
        tick();
        drive(1'b1, 2'b10, 6'h20, '0, '0); settle();
        check("stall_add", {63'h0, stall}, 64'h0);
        drive(1'b1, 2'b10, 6'h12, '0, '0); settle();
        check("stall_mflo", {63'h0, stall}, 64'h1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
            if (busy === 1'b1) check("stall_hold", {63'h0, stall}, 64'h1);
        end
        check("stall_lat", 64'(n), 64'd33);
        check("stall_release", {63'h0, stall}, 64'h0);
        check("mflo_sel", {62'h0, hilosel}, 64'h2);
        pop_check("mflo");
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        tick();

        // back-to-back mult then div
        drive(1'b1, 2'b10, 6'h18, 32'd100, 32'd200);
        exp_q.push_back({32'h0, 32'd20000});
        tick();
        drive(1'b1, 2'b10, 6'h1A, 32'd1000, 32'hFFFFFFF9); settle();
        check("b2b_stall", {63'h0, stall}, 64'h1);
        wait_idle(n);
        check("b2b_mult_lat", 64'(n), 64'd33);
        pop_check("b2b_mult");
        check("b2b_unstall", {63'h0, stall}, 64'h0);
        exp_q.push_back({32'h00000006, 32'hFFFFFF72});
        tick();
        check("b2b_div_start", {63'h0, busy}, 64'h1);
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        wait_idle(n);
        check("b2b_div_lat", 64'(n), 64'd33);
        pop_check("b2b_div");

        // reset in the middle of RUN
        drive(1'b1, 2'b10, 6'h19, 32'd3, 32'd3);
        tick();
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        repeat (10) tick();
        check("rst_mid_busy_before", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        drive(1'b1, 2'b10, 6'h12, '0, '0);
        tick();
        reset = 1'b0;
        settle();
        check("rst_mid_busy", {63'h0, busy}, 64'h0);
        check("rst_mid_hi", {32'h0, hi}, 64'h0);
        check("rst_mid_lo", {32'h0, lo}, 64'h0);
        check("rst_mid_stall", {63'h0, stall}, 64'h0);
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        tick();
        check("rst_mid_stays_idle", {63'h0, busy}, 64'h0);

        // mthi / mtlo
        drive(1'b1, 2'b10, 6'h11, 32'h00001234, '0);
        tick();
        drive(1'b1, 2'b10, 6'h10, '0, '0); settle();
        check("mthi_hi", {32'h0, hi}, 64'h1234);
        check("mthi_lo_kept", {32'h0, lo}, 64'h0);
        check("mfhi_sel", {62'h0, hilosel}, 64'h1);
        drive(1'b1, 2'b10, 6'h13, 32'h0000ABCD, '0);
        tick();
        drive(1'b0, 2'b00, 6'h00, '0, '0); settle();
        check("mtlo_lo", {32'h0, lo}, 64'hABCD);
        check("mtlo_hi_kept", {32'h0, hi}, 64'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
